// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the UART TX serializer
// and the RX parity checker.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        SHIFT = 2'd2
    } state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic LSB_FIRST = 1'b0;
    localparam logic MSB_FIRST = 1'b1;

    // Zero or oversize lengths mean a full-width frame.
    function automatic int unsigned clamp_len(
        input int unsigned len,
        input int unsigned max_len
    );
        if (len == 0 || len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/uart_parity_calc.sv
// Parity of the low len bits of a word.
// Shared by the TX serializer and the RX checker.
module uart_parity_calc
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_W      = $clog2(DATA_WIDTH) + 1
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [LEN_W-1:0]      len,
    input  logic                  par_type,
    output logic                  parity
);

    logic x;

    // XOR-reduce the frame bits, then apply the parity sense.
    always_comb begin
        x = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (LEN_W'(i) < len) begin
                x = x ^ data[i];
            end
        end
        parity = x;
        unique case (par_type)
            PAR_EVEN: parity = x;
            PAR_ODD:  parity = ~x;
        endcase
    end

endmodule

// File: rtl/uart_tx_serializer_cfg.sv
// UART TX bit serializer: loads a word, then shifts
// 1..DATA_WIDTH bits out LSB- or MSB-first under ser_en.
module uart_tx_serializer_cfg
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_W      = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [LEN_W-1:0]      data_len,
    input  logic                  msb_first,
    input  logic                  par_type,
    input  logic                  ser_en,
    output logic                  ser_data,
    output logic                  ser_done,
    output logic                  par_bit,
    output logic                  busy
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic                  msb_q, msb_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic                  ser_data_q, ser_data_d;
    logic                  ser_done_q, ser_done_d;
    logic                  par_q, par_d;

    logic [LEN_W-1:0]      len_c;
    logic                  par_c;
    logic [LEN_W-1:0]      bit_idx;
    logic [LEN_W-1:0]      cnt_inc;
    logic                  next_bit;
    logic                  last_bit;

    assign len_c = LEN_W'(clamp_len(32'(data_len), DATA_WIDTH));

    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH),
        .LEN_W      (LEN_W)
    ) u_par (
        .data     (p_data),
        .len      (len_c),
        .par_type (par_type),
        .parity   (par_c)
    );

    // Position of the next bit to send inside the held word.
    always_comb begin
        bit_idx = cnt_q;
        unique case (msb_q)
            LSB_FIRST: bit_idx = cnt_q;
            MSB_FIRST: bit_idx = len_q - LEN_W'(1) - cnt_q;
        endcase
    end

    assign next_bit = |(hold_q & (DATA_WIDTH'(1) << bit_idx));
    assign cnt_inc  = cnt_q + LEN_W'(1);
    assign last_bit = (cnt_inc == len_q);

    // Load / hold / shift sequencing and next output values.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        len_d      = len_q;
        msb_d      = msb_q;
        cnt_d      = cnt_q;
        ser_data_d = ser_data_q;
        ser_done_d = 1'b0;
        par_d      = par_q;
        unique case (state_q)
            IDLE: begin
                ser_data_d = 1'b0;
                if (load_valid) begin
                    hold_d  = p_data;
                    len_d   = len_c;
                    msb_d   = msb_first;
                    par_d   = par_c;
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                ser_data_d = 1'b0;
                if (ser_en) begin
                    ser_data_d = next_bit;
                    cnt_d      = cnt_inc;
                    if (last_bit) begin
                        ser_done_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (ser_en) begin
                    ser_data_d = next_bit;
                    cnt_d      = cnt_inc;
                    if (last_bit) begin
                        ser_done_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: begin
                ser_data_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any partial frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            len_q      <= '0;
            msb_q      <= LSB_FIRST;
            cnt_q      <= '0;
            ser_data_q <= 1'b0;
            ser_done_q <= 1'b0;
            par_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            len_q      <= len_d;
            msb_q      <= msb_d;
            cnt_q      <= cnt_d;
            ser_data_q <= ser_data_d;
            ser_done_q <= ser_done_d;
            par_q      <= par_d;
        end
    end

    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign ser_data   = ser_data_q;
    assign ser_done   = ser_done_q;
    assign par_bit    = par_q;

endmodule

// File: tb/tb_uart_tx_serializer_cfg.sv
// Scoreboard bench for uart_tx_serializer_cfg: directed
// frames from the test plan plus randomized frames.
module tb_uart_tx_serializer_cfg;

    localparam int DW = 8;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] p_data;
    logic          load_valid;
    logic          load_ready;
    logic [LW-1:0] data_len;
    logic          msb_first;
    logic          par_type;
    logic          ser_en;
    logic          ser_data;
    logic          ser_done;
    logic          par_bit;
    logic          busy;

    logic dir_en;
    logic rand_en;
    logic rand_ser = 1'b0;

    assign ser_en = rand_en ? rand_ser : dir_en;

    always #5 clk = ~clk;

    uart_tx_serializer_cfg #(
        .DATA_WIDTH (DW),
        .LEN_W      (LW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .p_data     (p_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .data_len   (data_len),
        .msb_first  (msb_first),
        .par_type   (par_type),
        .ser_en     (ser_en),
        .ser_data   (ser_data),
        .ser_done   (ser_done),
        .par_bit    (par_bit),
        .busy       (busy)
    );

    typedef struct {
        logic [DW-1:0] bits;
        int            len;
        logic          par;
    } frame_t;

    frame_t exp_q[$];
    logic   col[$];
    int     n_chk = 0;
    int     n_pass = 0;
    logic   shift_edge = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      nm, got, exp, $time);
    endtask

    // Reference: transmitted bit k in order, and parity by counting ones.
    function automatic frame_t model(input logic [DW-1:0] p,
                                     input logic [LW-1:0] l,
                                     input logic m, input logic pt);
        frame_t f;
        int     len;
        int     ones;
        len = (l == 0 || int'(l) > DW) ? DW : int'(l);
        f.len = len;
        f.bits = '0;
        ones = 0;
        for (int k = 0; k < len; k++) begin
            f.bits[k] = m ? p[len-1-k] : p[k];
            ones += int'(p[k]);
        end
        f.par = ((ones % 2) == 1) ^ pt;
        return f;
    endfunction

    always @(negedge clk) rand_ser = ($urandom_range(0, 3) != 0);

    always @(posedge clk) shift_edge <= ser_en && busy && reset;

    // Monitor: gather bits after each shifting edge, score on ser_done.
    always @(negedge clk) begin : mon
        frame_t        e;
        logic [DW-1:0] g;
        if (!reset) begin
            col.delete();
            chk("rst_ser_data", 32'(ser_data), 0);
            chk("rst_busy", 32'(busy), 0);
        end else begin
            if (shift_edge) col.push_back(ser_data);
            else if (busy && col.size() > 0)
                chk("pause_hold", 32'(ser_data), 32'(col[$]));
            else if (!ser_done)
                chk("idle_zero", 32'(ser_data), 0);
            chk("ready_vs_busy", 32'(load_ready), 32'(!busy));
            if (ser_done) begin
                g = '0;
                foreach (col[i]) if (i < DW) g[i] = col[i];
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_len", col.size(), e.len);
                    chk("frame_bits", 32'(g), 32'(e.bits));
                    chk("frame_par", 32'(par_bit), 32'(e.par));
                end
                col.delete();
            end
        end
    end

    task automatic do_load(input logic [DW-1:0] p, input logic [LW-1:0] l,
                           input logic m, input logic pt);
        int n;
        n = 0;
        while (!load_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!load_ready) begin
            chk("load_ready_timeout", 0, 1);
            return;
        end
        p_data = p;
        data_len = l;
        msb_first = m;
        par_type = pt;
        load_valid = 1'b1;
        exp_q.push_back(model(p, l, m, pt));
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("frame_end_timeout", 32'(busy), 0);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        p_data = '0;
        load_valid = 1'b0;
        data_len = '0;
        msb_first = 1'b0;
        par_type = 1'b0;
        dir_en = 1'b0;
        rand_en = 1'b0;
        #1;
        chk("reset_ser_done", 32'(ser_done), 0);
        chk("reset_par_bit", 32'(par_bit), 0);
        chk("reset_load_ready", 32'(load_ready), 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // LSB-first, even parity
        do_load(8'hB1, 4'd8, 1'b0, 1'b0);
        dir_en = 1'b1;
        wait_idle();
        // MSB-first, odd parity
        do_load(8'hB1, 4'd8, 1'b1, 1'b1);
        wait_idle();
        // short frame and zero length
        do_load(8'h3B, 4'd5, 1'b0, 1'b0);
        wait_idle();
        do_load(8'hA7, 4'd0, 1'b0, 1'b0);
        wait_idle();
        do_load(8'h96, 4'd1, 1'b1, 1'b1);
        wait_idle();

        // pause three cycles after the third bit
        dir_en = 1'b0;
        do_load(8'hB1, 4'd8, 1'b0, 1'b0);
        dir_en = 1'b1;
        repeat (3) @(negedge clk);
        dir_en = 1'b0;
        repeat (3) @(negedge clk);
        dir_en = 1'b1;
        wait_idle();

        // back-to-back load in the ser_done cycle
        do_load(8'hB1, 4'd8, 1'b0, 1'b0);
        n = 0;
        while (!ser_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_done_seen", 32'(ser_done), 1);
        p_data = 8'h55;
        data_len = 4'd8;
        msb_first = 1'b0;
        par_type = 1'b0;
        load_valid = 1'b1;
        exp_q.push_back(model(8'h55, 4'd8, 1'b0, 1'b0));
        @(negedge clk);
        load_valid = 1'b0;
        chk("b2b_accepted", 32'(busy), 1);
        wait_idle();

        // load attempt while holding is ignored
        dir_en = 1'b0;
        do_load(8'hC3, 4'd8, 1'b0, 1'b0);
        p_data = 8'h3C;
        msb_first = 1'b1;
        par_type = 1'b1;
        load_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("hold_not_ready", 32'(load_ready), 0);
        load_valid = 1'b0;
        dir_en = 1'b1;
        wait_idle();

        // reset after the fourth bit
        dir_en = 1'b0;
        do_load(8'hB1, 4'd8, 1'b0, 1'b0);
        dir_en = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_ser_data", 32'(ser_data), 0);
        chk("async_ser_done", 32'(ser_done), 0);
        chk("async_par_bit", 32'(par_bit), 0);
        chk("async_busy", 32'(busy), 0);
        chk("async_ready", 32'(load_ready), 1);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        dir_en = 1'b0;
        do_load(8'hB1, 4'd8, 1'b0, 1'b0);
        dir_en = 1'b1;
        wait_idle();

        // randomized frames with random ser_en
        rand_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            do_load(8'($urandom), 4'($urandom_range(0, 12)),
                    1'($urandom), 1'($urandom));
        end
        wait_idle();
        rand_en = 1'b0;
        repeat (2) @(negedge clk);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
